hazard_ctrl: RTL

- Parametrised hazard, interlock and forwarding controller for the 5-stage core.
- Successor to the fixed-function hazard unit. Adds:
  - a multi-cycle multiplier interlock with configurable latency;
  - separate I-cache and D-cache stall handling, plus an explicit Memory-stage stall;
  - a saturating stall-cycle performance counter.
- Sits beside the pipeline and drives stall, flush and forward controls for fetch through memory.

---
 rtl/hazard_ctrl_pkg.sv | 22 ++
 rtl/hazard_ctrl_forward_sel.sv | 27 ++
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the hazard / interlock / forwarding controller.
package hazard_ctrl_pkg;

  // Operand source selects driven onto ForwardAE / ForwardBE.
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file value
  localparam logic [1:0] FWD_W    = 2'b01;  // Writeback result
  localparam logic [1:0] FWD_M    = 2'b10;  // Memory-stage ALU result

  // Multiplier interlock FSM states.
  typedef enum logic [0:0] {
    HZ_IDLE     = 1'b0,
    HZ_MUL_BUSY = 1'b1
  } hz_state_e;

  // Memory-stage producer is younger than Writeback, so it wins when both match.
  function automatic logic [1:0] fwd_priority(input logic hit_m, input logic hit_w);
    if (hit_m)      fwd_priority = FWD_M;
    else if (hit_w) fwd_priority = FWD_W;
    else            fwd_priority = FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_forward_sel.sv
// Per-operand forwarding select: compares one Execute source register against
// the Memory and Writeback destinations and picks the youngest valid producer.
// Register x0 is hardwired to zero and is never forwarded.
module forward_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_w,
  output logic [1:0]            fwd
);

  logic hit_m;
  logic hit_w;

  // Match detection against each in-flight producer, then priority pick.
  always_comb begin
    hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e);
    hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e);
    fwd   = fwd_priority(hit_m, hit_w);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, interlock and forwarding controller for the 5-stage core.
// Generates stall/flush controls for F..M, operand forwarding selects for
// Execute, a multi-cycle multiply interlock and a saturating stall counter.
//
// Handshake note: this block has no valid/ready channels; every input is a
// level describing the current cycle's pipeline contents and every output is
// a level the pipeline registers obey in that same cycle.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  ResultSrcE0,
  input  logic                  MulE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic                  RegWriteM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteW,
  input  logic                  PCSrcE,
  input  logic                  iCacheStall,
  input  logic                  dCacheStall,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [CNT_W-1:0]      StallCycles,
  output hz_state_e             dbg_state
);

  // The counter only ever needs to hold MUL_LATENCY-1.
  localparam int MC_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [MC_W-1:0] MUL_LOAD = MC_W'(MUL_LATENCY - 1);
  localparam logic [MC_W-1:0] MC_ONE   = MC_W'(1);
  localparam bit MUL_INTERLOCK = (MUL_LATENCY > 1);

  hz_state_e        state_q, state_d;
  logic [MC_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic       mul_stall;
  logic       lw_stall;
  logic       stall_e_raw;
  logic       stall_d_raw;
  logic       stall_f_raw;
  logic       flush_d_raw;
  logic       flush_e_raw;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a_raw)
  );

  forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b_raw)
  );

  // Multiply interlock next-state: hold Execute for MUL_LATENCY cycles, and
  // freeze the countdown whenever the D-cache is holding the whole back end.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    case (state_q)
      HZ_IDLE: begin
        if (MulE && MUL_INTERLOCK && !dCacheStall) begin
          mul_stall = 1'b1;
          cnt_d     = MUL_LOAD;
          state_d   = HZ_MUL_BUSY;
        end
      end
      HZ_MUL_BUSY: begin
        mul_stall = (cnt_q > MC_ONE);
        if (!dCacheStall) begin
          if (cnt_q == MC_ONE) begin
            // Release cycle: the multiply result leaves Execute this cycle.
            cnt_d   = '0;
            state_d = HZ_IDLE;
          end else begin
            cnt_d = cnt_q - MC_ONE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = HZ_IDLE;
      end
    endcase
  end

  // Stall and flush equations; a D-cache stall suppresses every flush so no
  // instruction is lost while the back end is frozen.
  always_comb begin
    lw_stall    = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    stall_e_raw = dCacheStall || mul_stall;
    stall_d_raw = stall_e_raw || lw_stall;
    stall_f_raw = stall_d_raw || iCacheStall;
    flush_e_raw = !dCacheStall && !mul_stall && (lw_stall || PCSrcE);
    flush_d_raw = !dCacheStall && (PCSrcE || (iCacheStall && !stall_d_raw));
  end

  // While reset is low the pipeline is held in a bubbled, non-stalled state.
  always_comb begin
    if (!rst) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      ForwardAE = FWD_NONE;
      ForwardBE = FWD_NONE;
    end else begin
      StallF    = stall_f_raw;
      StallD    = stall_d_raw;
      StallE    = stall_e_raw;
      StallM    = dCacheStall;
      FlushD    = flush_d_raw;
      FlushE    = flush_e_raw;
      ForwardAE = fwd_a_raw;
      ForwardBE = fwd_b_raw;
    end
  end

  // Stall-cycle counter next value: count fetch-stall cycles, stick at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_f_raw && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // State registers; reset aborts any multiply in flight immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= HZ_IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign dbg_state   = state_q;

endmodule
